aes_serial_if: RTL and testbench
================================

AES_SERIAL_IF -- requirements
Module: aes_serial_if

Interface
REQ-001 Parameter DW, default 8, beat width in bits; SHALL be one of 8, 16, 32, 64; NB = 128/DW beats per block.
REQ-002 Parameter TIMEOUT, default 64, maximum cycles to wait for core_done after core_start.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 loadkey  in  1  key beat strobe.
REQ-006 load_shift  in  1  data beat strobe; shifts din in and dout out.
REQ-007 staenc / stadec  in  1 each  start-encrypt / start-decrypt request.
REQ-008 keylen  in  2  00 = 128, 01 = 192, 10 = 256 bits, 11 = reserved.
REQ-009 din  in  DW  input beat. dout  out  DW  output beat.
REQ-010 core_start  out  1  one-cycle start pulse. core_dec  out  1  1 = decrypt.
REQ-011 core_key  out  256  key, right-aligned and zero-extended. core_blk  out  128  block to core.
REQ-012 core_done  in  1  result strobe. core_result  in  128  result block.
REQ-013 key_valid, busy, out_valid, err  out  1 each  status; err is a one-cycle pulse.

Function
REQ-014 Beat order SHALL be least-significant beat first: sreg <= {din, sreg[127:DW]}, and dout = sreg[DW-1:0] combinationally.
REQ-015 Key register SHALL be 256 bits: kreg <= {din, kreg[255:DW]} per loadkey beat; core_key = kreg[255:256-KL] zero-extended, with KL = 128/192/256.
REQ-016 keylen SHALL be sampled into klen_q on the loadkey beat where key_cnt == 0; later changes are ignored until the key is reloaded.
REQ-017 key_cnt SHALL count loadkey beats and saturate at KL/DW; key_valid = (key_cnt == KL/DW).
REQ-018 A loadkey beat when key_cnt is saturated SHALL restart loading: key_cnt = 1, and klen_q is resampled.
REQ-019 keylen = 11 at the sampling beat SHALL pulse err and leave kreg, key_cnt and klen_q unchanged.
REQ-020 data_cnt SHALL count load_shift beats in IDLE and saturate at NB.
REQ-021 out_cnt, when nonzero, SHALL decrement on each load_shift beat; out_valid = (out_cnt != 0).
REQ-022 The FSM SHALL have exactly two states, IDLE and RUN; busy = (state == RUN).
REQ-023 IDLE->RUN SHALL occur on exactly one of staenc/stadec with key_valid = 1 and data_cnt == NB.
REQ-024 On that IDLE->RUN transition, the next cycle SHALL have core_start = 1 and core_dec = stadec, and data_cnt SHALL clear.
REQ-025 core_blk = sreg and core_key SHALL stay stable throughout RUN; loadkey and load_shift in RUN SHALL be ignored and pulse err.
REQ-026 RUN->IDLE on core_done: sreg <= core_result, out_cnt <= NB, data_cnt <= 0.
REQ-027 RUN->IDLE on timeout (TIMEOUT cycles after core_start without core_done): pulse err, leave sreg unchanged, out_cnt = 0.
REQ-028 Simultaneous staenc and stadec, a start without key_valid or with data_cnt < NB, or a start while busy SHALL be ignored and pulse err.
REQ-029 Simultaneous loadkey and load_shift SHALL pulse err, and neither register changes.
REQ-030 core_done while in IDLE SHALL be ignored.
REQ-031 A result unload SHALL overlap a new block load: each beat outputs one result beat and loads one din beat.

Reset
REQ-032 On rst = 1, immediately and independent of clk: sreg, kreg, klen_q, key_cnt, data_cnt, out_cnt and the timeout counter = 0; state = IDLE.
REQ-033 On rst = 1, all outputs SHALL be 0: dout, core_start, core_dec, key_valid, busy, out_valid, err.
REQ-034 Reset asserted during RUN SHALL abandon the operation; a later core_done SHALL be ignored.

Verification
REQ-035 DW=8, keylen=00: load key beats 0f..00, block beats ff..00, staenc, core model returns AES -> core_start one cycle after request, then 16 unload beats give dout 5a,c5,...,c4,69 (result 69c4e0d86a7b0430d8cdb78070b4c55a).
REQ-036 Load 16 beats 5a..69, stadec -> 16 unload beats give dout ff,ee,...,11,00.
REQ-037 DW=32, keylen=10: 8 key beats -> key_valid = 1 only after the 8th beat; core_key = 000102...1f; FIPS-197 256-bit vector passes.
REQ-038 Start after 15 of 16 beats, then staenc+stadec together, then staenc during RUN -> err pulse each time, no core_start.
REQ-039 Core model never asserts done -> err exactly TIMEOUT cycles after core_start, busy = 0, out_valid = 0.
REQ-040 rst pulse mid-RUN, then a late core_done -> all outputs 0, state stays IDLE, sreg stays 0.

Source files
------------

// File: rtl/aes_serial_if.sv
// Serial front end for a 128-bit block cipher core: beat-wise key/data loading,
// start/timeout sequencing and overlapped result unloading.
module aes_serial_if #(
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          loadkey,
  input  logic          load_shift,
  input  logic          staenc,
  input  logic          stadec,
  input  logic [1:0]    keylen,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          core_start,
  output logic          core_dec,
  output logic [255:0]  core_key,
  output logic [127:0]  core_blk,
  input  logic          core_done,
  input  logic [127:0]  core_result,
  output logic          key_valid,
  output logic          busy,
  output logic          out_valid,
  output logic          err
);

  localparam int unsigned NB   = 128 / DW;
  localparam int unsigned KMAX = 256 / DW;
  localparam int unsigned KCW  = $clog2(KMAX + 1);
  localparam int unsigned DCW  = $clog2(NB + 1);
  localparam int unsigned TCW  = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_d;
  logic [127:0]   sreg;
  logic [255:0]   kreg;
  logic [1:0]     klen_q;
  logic [KCW-1:0] key_cnt, kbeats;
  logic [DCW-1:0] data_cnt, out_cnt;
  logic [TCW-1:0] tcnt;
  logic           start_q, dec_q, err_q;

  logic load_blocked, key_beat, data_beat, key_sample, key_bad;
  logic start_ok, start_bad, run_tout, err_d;

  always_comb begin
    kbeats = KCW'(128 / DW);
    case (klen_q)
      2'b01:   kbeats = KCW'(192 / DW);
      2'b10:   kbeats = KCW'(256 / DW);
      default: kbeats = KCW'(128 / DW);
    endcase
  end

  assign key_valid = (key_cnt == kbeats);

  // Loads are refused while a block is with the core and also on the cycle a
  // start is accepted, so the key and block handed over cannot shift under it.
  always_comb begin
    start_ok     = (state == IDLE) && (staenc ^ stadec) && key_valid &&
                   (data_cnt == DCW'(NB));
    start_bad    = (staenc | stadec) && !start_ok;
    load_blocked = (state == RUN) || start_ok;
    key_beat     = loadkey && !load_shift && !load_blocked;
    data_beat    = load_shift && !loadkey && !load_blocked;
    key_sample   = key_beat && ((key_cnt == '0) || key_valid);
    key_bad      = key_sample && (keylen == 2'b11);
    run_tout     = (state == RUN) && !core_done && (tcnt == TCW'(TIMEOUT - 1));
    err_d        = (loadkey & load_shift) | ((loadkey | load_shift) & load_blocked) |
                   key_bad | start_bad | run_tout;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (core_done || run_tout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg     <= '0;
      kreg     <= '0;
      klen_q   <= '0;
      key_cnt  <= '0;
      data_cnt <= '0;
      out_cnt  <= '0;
      tcnt     <= '0;
      start_q  <= 1'b0;
      dec_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      start_q <= start_ok;
      err_q   <= err_d;

      if (key_beat) begin
        if (key_sample) begin
          if (!key_bad) begin
            kreg    <= {din, kreg[255:DW]};
            klen_q  <= keylen;
            key_cnt <= KCW'(1);
          end
        end else begin
          kreg    <= {din, kreg[255:DW]};
          key_cnt <= key_cnt + KCW'(1);
        end
      end

      if (data_beat) begin
        sreg <= {din, sreg[127:DW]};
        if (data_cnt != DCW'(NB)) data_cnt <= data_cnt + DCW'(1);
        if (out_cnt != '0)        out_cnt  <= out_cnt - DCW'(1);
      end

      if (start_ok) begin
        dec_q    <= stadec;
        data_cnt <= '0;
        tcnt     <= '0;
      end

      if (state == RUN) begin
        tcnt <= tcnt + TCW'(1);
        if (core_done) begin
          sreg     <= core_result;
          out_cnt  <= DCW'(NB);
          data_cnt <= '0;
        end else if (run_tout) begin
          out_cnt <= '0;
        end
      end
    end
  end

  always_comb begin
    core_key = '0;
    case (klen_q)
      2'b01:   core_key = {64'd0, kreg[255:64]};
      2'b10:   core_key = kreg;
      default: core_key = {128'd0, kreg[255:128]};
    endcase
  end

  assign core_blk   = sreg;
  assign dout       = sreg[DW-1:0];
  assign core_start = start_q;
  assign core_dec   = dec_q;
  assign err        = err_q;
  assign busy       = (state == RUN);
  assign out_valid  = (out_cnt != '0);

endmodule

// File: tb/tb_aes_serial_if.sv
// Directed bench for aes_serial_if: an 8-bit/128-bit-key instance and a
// 32-bit/256-bit-key instance, with the cipher core replaced by FIPS-197 answers.
module tb_aes_serial_if;

  localparam int unsigned TO8  = 64;
  localparam int unsigned TO32 = 20;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] BLK2  = 128'h1f1e1d1c1b1a19181716151413121110;
  localparam logic [127:0] KNEW  = 128'h44444444333333332222222211111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         lk8 = 0, ls8 = 0, se8 = 0, sd8 = 0, done8 = 0;
  logic [1:0]   kl8 = '0;
  logic [7:0]   din8 = '0, dout8;
  logic [127:0] res8 = '0, cb8;
  logic [255:0] ck8;
  logic         cs8, cd8, kv8, busy8, ov8, err8;

  logic         lk32 = 0, ls32 = 0, se32 = 0, sd32 = 0, done32 = 0;
  logic [1:0]   kl32 = '0;
  logic [31:0]  din32 = '0, dout32;
  logic [127:0] res32 = '0, cb32;
  logic [255:0] ck32;
  logic         cs32, cd32, kv32, busy32, ov32, err32;

  aes_serial_if #(.DW(8), .TIMEOUT(TO8)) u8 (
    .clk(clk), .rst(rst), .loadkey(lk8), .load_shift(ls8), .staenc(se8),
    .stadec(sd8), .keylen(kl8), .din(din8), .dout(dout8), .core_start(cs8),
    .core_dec(cd8), .core_key(ck8), .core_blk(cb8), .core_done(done8),
    .core_result(res8), .key_valid(kv8), .busy(busy8), .out_valid(ov8), .err(err8)
  );

  aes_serial_if #(.DW(32), .TIMEOUT(TO32)) u32 (
    .clk(clk), .rst(rst), .loadkey(lk32), .load_shift(ls32), .staenc(se32),
    .stadec(sd32), .keylen(kl32), .din(din32), .dout(dout32), .core_start(cs32),
    .core_dec(cd32), .core_key(ck32), .core_blk(cb32), .core_done(done32),
    .core_result(res32), .key_valid(kv32), .busy(busy32), .out_valid(ov32), .err(err32)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;

    // reset state
    #1;
    check("rst8_outs",  {dout8, cs8, cd8, kv8, busy8, ov8, err8}, '0);
    check("rst32_outs", {dout32, cs32, cd32, kv32, busy32, ov32, err32}, '0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // 128-bit key on the 8-bit instance, beats 0f..00
    for (int i = 0; i < 16; i++) begin
      lk8 = 1; kl8 = 2'b00; din8 = 8'(15 - i);
      cyc();
      if (i == 14) check("kv8_15beats", kv8, 0);
    end
    lk8 = 0;
    check("kv8_16beats", kv8, 1);
    check("key8_128", ck8, {128'd0, K128});

    // premature start after 15 of 16 data beats
    for (int i = 0; i < 15; i++) begin
      ls8 = 1; din8 = PT[8*i +: 8];
      cyc();
    end
    ls8 = 0; se8 = 1;
    cyc();
    se8 = 0;
    check("short_start_err", {err8, cs8, busy8}, 3'b100);
    ls8 = 1; din8 = PT[127:120];
    cyc();
    ls8 = 0;

    // both start requests at once
    se8 = 1; sd8 = 1;
    cyc();
    sd8 = 0;
    check("dual_start_err", {err8, cs8, busy8}, 3'b100);

    // accepted encrypt, then a start while busy
    cyc();
    check("enc_start", {cs8, cd8, busy8, err8}, 4'b1010);
    check("enc_blk", cb8, PT);
    check("enc_key", ck8, {128'd0, K128});
    cyc();
    se8 = 0;
    check("busy_start_err", {err8, cs8, busy8}, 3'b101);
    done8 = 1; res8 = CT128;
    cyc();
    done8 = 0;
    check("enc_done", {busy8, ov8}, 2'b01);

    // unload ciphertext while loading it back for decryption
    for (int i = 0; i < 16; i++) begin
      check($sformatf("enc_dout%0d", i), dout8, CT128[8*i +: 8]);
      ls8 = 1; din8 = CT128[8*i +: 8];
      cyc();
    end
    ls8 = 0;
    check("enc_unload_end", ov8, 0);

    sd8 = 1;
    cyc();
    sd8 = 0;
    check("dec_start", {cs8, cd8, busy8}, 3'b111);
    check("dec_blk", cb8, CT128);
    done8 = 1; res8 = PT;
    cyc();
    done8 = 0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("dec_dout%0d", i), dout8, PT[8*i +: 8]);
      ls8 = 1; din8 = 8'(8'h10 + i);
      cyc();
    end
    ls8 = 0;

    // core never answers
    se8 = 1;
    cyc();
    se8 = 0;
    check("to_start", cs8, 1);
    n = 0;
    while (n < 200) begin
      cyc();
      n++;
      if (err8) break;
    end
    check("to_cycles", n, TO8);
    check("to_status", {busy8, ov8}, 2'b00);
    check("to_sreg", cb8, BLK2);

    // reset mid-run, then a late core_done
    for (int i = 0; i < 16; i++) begin
      ls8 = 1; din8 = 8'(8'h30 + i);
      cyc();
    end
    ls8 = 0; sd8 = 1;
    cyc();
    sd8 = 0;
    check("rr_start", {cs8, cd8, busy8}, 3'b111);
    cyc(); cyc();
    rst = 1'b1;
    #1;
    check("rr_async_outs", {dout8, cs8, cd8, kv8, busy8, ov8, err8}, '0);
    cyc();
    rst = 1'b0;
    done8 = 1; res8 = CT128;
    cyc();
    done8 = 0;
    cyc();
    check("rr_late_done", {dout8, cs8, cd8, kv8, busy8, ov8, err8}, '0);
    check("rr_sreg", cb8, '0);

    // 32-bit instance: reserved keylen at the sampling beat
    lk32 = 1; kl32 = 2'b11; din32 = 32'hffffffff;
    cyc();
    lk32 = 0;
    check("klen11_err", {err32, kv32}, 2'b10);
    check("klen11_key", ck32, '0);

    // 256-bit key; keylen moves after the first beat and must be ignored
    for (int i = 0; i < 8; i++) begin
      lk32 = 1; kl32 = (i == 0) ? 2'b10 : 2'b00; din32 = K256[32*i +: 32];
      cyc();
      if (i == 6) check("kv32_7beats", kv32, 0);
    end
    lk32 = 0;
    check("kv32_8beats", kv32, 1);
    check("key32_256", ck32, K256);

    lk32 = 1; ls32 = 1; din32 = 32'hdeadbeef;
    cyc();
    lk32 = 0; ls32 = 0;
    check("both_load_err", {err32, kv32}, 2'b11);
    check("both_load_key", ck32, K256);

    for (int i = 0; i < 4; i++) begin
      ls32 = 1; din32 = PT[32*i +: 32];
      cyc();
    end
    ls32 = 0; se32 = 1;
    cyc();
    se32 = 0;
    check("e32_start", {cs32, cd32, busy32}, 3'b101);
    check("e32_blk", cb32, PT);
    lk32 = 1; din32 = 32'h12345678;
    cyc();
    lk32 = 0;
    check("run_key_err", {err32, busy32}, 2'b11);
    check("run_key_hold", ck32, K256);
    done32 = 1; res32 = CT256;
    cyc();
    done32 = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("e32_dout%0d", i), dout32, CT256[32*i +: 32]);
      ls32 = 1; din32 = '0;
      cyc();
    end
    ls32 = 0;
    check("e32_unload_end", ov32, 0);

    // core_done in IDLE
    done32 = 1; res32 = '1;
    cyc();
    done32 = 0;
    check("idle_done", {busy32, ov32, dout32}, '0);

    // reloading a complete key restarts the count with a fresh keylen
    for (int i = 0; i < 4; i++) begin
      lk32 = 1; kl32 = 2'b00; din32 = KNEW[32*i +: 32];
      cyc();
      if (i == 0) check("reload_kv", kv32, 0);
    end
    lk32 = 0;
    check("reload_kv_done", kv32, 1);
    check("reload_key128", ck32, {128'd0, KNEW});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
